// File: rtl/rand_range_sampler.sv
// rand_range_sampler
// Draws unbiased integers in [0, range) from a free-running PRNG stream using
// mask-and-reject sampling. Each request is served over a valid/ready
// handshake. After MAX_TRIES rejected draws the last candidate is folded back
// into range, and the result is flagged as a fallback.
module rand_range_sampler #(
    parameter int WIDTH     = 16,
    parameter int OUT_W     = 8,
    parameter int MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             prng_enable,
    input  logic [WIDTH-1:0] prng_num,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W:0]   req_range,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_fallback,
    output logic             out_err,
    output logic [15:0]      stat_rejects,
    output logic [15:0]      stat_fallbacks
);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   RANGE_ONE = 1;

    state_t           state_q;
    logic [OUT_W:0]   range_q;
    logic [OUT_W-1:0] mask_q;
    logic [TRY_W-1:0] tries_q;
    logic [OUT_W-1:0] out_value_q;
    logic             out_fallback_q;
    logic             out_err_q;
    logic [15:0]      stat_rejects_q;
    logic [15:0]      stat_fallbacks_q;

    logic [OUT_W-1:0] range_m1_d;
    logic [OUT_W-1:0] mask_d;
    logic [OUT_W-1:0] cand_d;
    logic [OUT_W-1:0] excess_d;
    logic             accept_d;

    // For ranges 1..2^OUT_W, range-1 always fits in OUT_W bits.
    assign range_m1_d = OUT_W'(req_range - RANGE_ONE);

    // The mask is range-1 with every bit below its leading one set,
    // i.e. (smallest power of two >= range) - 1.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_mask
            assign mask_d[gi] = |range_m1_d[OUT_W-1:gi];
        end
    endgenerate

    // Only the low OUT_W bits of the PRNG word are used.
    generate
        if (WIDTH > OUT_W) begin : g_unused_prng
            logic unused_prng_bits;
            assign unused_prng_bits = ^prng_num[WIDTH-1:OUT_W];
        end
    endgenerate

    assign cand_d   = prng_num[OUT_W-1:0] & mask_q;
    assign accept_d = ({1'b0, cand_d} < range_q);
    // When a candidate is rejected it lies in [range, mask], and mask < 2*range.
    // Subtracting the range therefore always lands inside [0, range).
    assign excess_d = cand_d - range_q[OUT_W-1:0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Request/draw/hold sequencer with its statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            range_q          <= '0;
            mask_q           <= '0;
            tries_q          <= '0;
            out_value_q      <= '0;
            out_fallback_q   <= 1'b0;
            out_err_q        <= 1'b0;
            stat_rejects_q   <= '0;
            stat_fallbacks_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_range != '0) begin
                            range_q <= req_range;
                            mask_q  <= mask_d;
                            tries_q <= '0;
                            state_q <= DRAW;
                        end else begin
                            out_value_q    <= '0;
                            out_err_q      <= 1'b1;
                            out_fallback_q <= 1'b0;
                            state_q        <= HOLD;
                        end
                    end
                end
                DRAW: begin
                    if (accept_d) begin
                        out_value_q    <= cand_d;
                        out_fallback_q <= 1'b0;
                        out_err_q      <= 1'b0;
                        state_q        <= HOLD;
                    end else if (tries_q != LAST_TRY) begin
                        tries_q        <= tries_q + 1'b1;
                        stat_rejects_q <= sat_inc(stat_rejects_q);
                    end else begin
                        out_value_q      <= excess_d;
                        out_fallback_q   <= 1'b1;
                        out_err_q        <= 1'b0;
                        stat_rejects_q   <= sat_inc(stat_rejects_q);
                        stat_fallbacks_q <= sat_inc(stat_fallbacks_q);
                        state_q          <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_err_q      <= 1'b0;
                        out_fallback_q <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prng_enable    = (state_q == DRAW);
    assign req_ready      = (state_q == IDLE);
    assign out_valid      = (state_q == HOLD);
    assign out_value      = out_value_q;
    assign out_fallback   = out_fallback_q;
    assign out_err        = out_err_q;
    assign stat_rejects   = stat_rejects_q;
    assign stat_fallbacks = stat_fallbacks_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler. It models the PRNG as a queue of
// values that advances on prng_enable, and uses a scoreboard of expected results.
module tb_rand_range_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        prng_enable;
    logic [15:0] prng_num;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_range;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_value;
    logic        out_fallback;
    logic        out_err;
    logic [15:0] stat_rejects;
    logic [15:0] stat_fallbacks;

    rand_range_sampler #(.WIDTH(16), .OUT_W(8), .MAX_TRIES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .prng_enable   (prng_enable),
        .prng_num      (prng_num),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_range     (req_range),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_value     (out_value),
        .out_fallback  (out_fallback),
        .out_err       (out_err),
        .stat_rejects  (stat_rejects),
        .stat_fallbacks(stat_fallbacks)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] value;
        logic       fallback;
        logic       err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] prng_q[$];
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: the enable seen in the current cycle advances the PRNG model.
    task automatic tick();
        logic en;
        en = prng_enable;
        @(posedge clk);
        #1;
        if (en === 1'b1) begin
            en_cnt++;
            if (prng_q.size() > 0) prng_num = prng_q.pop_front();
        end
    endtask

    task automatic run_req(input logic [8:0] rng, input logic [7:0] ev, input logic efb,
                           input logic eerr, input int elat, input int een, input int ehold);
        exp_t e;
        exp_t got;
        int   k;
        int   en0;
        check("req_ready_idle", req_ready, 1);
        e.value = ev;
        e.fallback = efb;
        e.err = eerr;
        sb.push_back(e);
        req_valid = 1'b1;
        req_range = rng;
        en0 = en_cnt;
        tick();
        req_valid = 1'b0;
        req_range = '0;
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("latency", k, elat);
        check("prng_enable_cycles", en_cnt - en0, een);
        if (out_valid === 1'b1 && sb.size() > 0) begin
            got = sb.pop_front();
            check("out_value", out_value, got.value);
            check("out_fallback", out_fallback, got.fallback);
            check("out_err", out_err, got.err);
        end
        for (int i = 0; i < ehold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_value", out_value, ev);
            check("hold_req_ready", req_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_req_ready", req_ready, 1);
        check("post_err", out_err, 0);
        check("post_fallback", out_fallback, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_range = '0;
        out_ready = 1'b0;
        prng_num  = 16'h0000;
        #1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_prng_enable", prng_enable, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_fallback", out_fallback, 0);
        check("rst_stat_rejects", stat_rejects, 0);
        check("rst_stat_fallbacks", stat_fallbacks, 0);

        // One rejection (240 >= 200), then 0x34 is accepted.
        prng_num = 16'h00F0;
        prng_q.push_back(16'h1234);
        run_req(9'd200, 8'h34, 1'b0, 1'b0, 3, 2, 0);
        $display("txn range=200 reject-then-accept value=%0d", out_value);
        check("t1_stat_rejects", stat_rejects, 1);

        // Range 1 always yields 0; range 256 always accepts.
        prng_num = 16'hFFFF;
        run_req(9'd1, 8'h00, 1'b0, 1'b0, 2, 1, 0);
        $display("txn range=1 value=%0d", out_value);
        prng_num = 16'hABFF;
        run_req(9'd256, 8'hFF, 1'b0, 1'b0, 2, 1, 0);
        $display("txn range=256 value=%0d", out_value);
        check("edge_stat_rejects", stat_rejects, 1);

        // Range 5 (mask 7): 7 rejected, then 3 accepted.
        prng_num = 16'h0007;
        prng_q.push_back(16'h0003);
        run_req(9'd5, 8'd3, 1'b0, 1'b0, 3, 2, 0);
        $display("txn range=5 value=%0d", out_value);
        check("r5_stat_rejects", stat_rejects, 2);

        // Fallback: 0xFF is rejected 16 times, and 255-200 = 55.
        prng_num = 16'h00FF;
        run_req(9'd200, 8'd55, 1'b1, 1'b0, 17, 16, 0);
        $display("txn range=200 fallback value=%0d", out_value);
        check("fb_stat_rejects", stat_rejects, 18);
        check("fb_stat_fallbacks", stat_fallbacks, 1);

        // Error path: the PRNG is never advanced.
        run_req(9'd0, 8'd0, 1'b0, 1'b1, 1, 0, 0);
        $display("txn range=0 err");

        // Backpressure for 5 cycles in HOLD.
        prng_num = 16'h0034;
        run_req(9'd200, 8'd52, 1'b0, 1'b0, 2, 1, 5);
        $display("txn range=200 backpressure value=%0d", out_value);

        // Reset in the 2nd DRAW cycle of a rejecting sequence aborts the request.
        prng_num = 16'h00FF;
        req_valid = 1'b1;
        req_range = 9'd200;
        tick();
        req_valid = 1'b0;
        req_range = '0;
        tick();
        check("mid_draw_enable", prng_enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_req_ready", req_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_prng_enable", prng_enable, 0);
        check("abort_out_value", out_value, 0);
        check("abort_stat_rejects", stat_rejects, 0);
        check("abort_stat_fallbacks", stat_fallbacks, 0);
        $display("txn reset mid-draw aborted");

        // A fresh range 4 request: 6 & 3 = 2 is accepted.
        prng_num = 16'h0006;
        run_req(9'd4, 8'd2, 1'b0, 1'b0, 2, 1, 0);
        $display("txn range=4 value=%0d", out_value);
        check("final_stat_rejects", stat_rejects, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
